mseq_sync_ctrl: RTL and testbench

- Frame-acquisition controller that sits directly behind the `dec` m-sequence correlator (31-chip template, 8-bit correlation output, full-match value 62).
- Watches the correlator score each chip, finds a first peak and tracks chip phase modulo the sequence length.
- Declares lock after repeated peaks at the expected period and drops lock after repeated misses.
- Pulses the correlator buffer clear after a search timeout or a lost lock, so downstream logic receives a clean frame strobe and phase.

---
 rtl/mseq_pkg.sv | 19 +
 rtl/mseq_phase_cnt.sv | 38 +++
 rtl/mseq_sync_ctrl.sv | 155 +++++++++++++++
 tb/tb_mseq_sync_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mseq_pkg.sv
// rtl/mseq_pkg.sv - shared constants and state encoding for the m-sequence sync controller
package mseq_pkg;

  localparam int SEQ_LEN    = 31;
  localparam int CORR_W     = 8;
  localparam int PEAK_MAX   = 62;
  localparam int PEAK_THR   = 56;
  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 2;
  localparam int SEARCH_TO  = 124;
  localparam int PHASE_W    = $clog2(SEQ_LEN);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_e;

endpackage

// File: rtl/mseq_phase_cnt.sv
// rtl/mseq_phase_cnt.sv - modulo-SEQ_LEN chip phase counter with registered wrap flag
module mseq_phase_cnt #(
  parameter int SEQ_LEN = 31
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_zero,
  input  logic                       en,
  output logic [$clog2(SEQ_LEN)-1:0] phase,
  output logic                       wrap
);

  localparam int W = $clog2(SEQ_LEN);
  localparam logic [W-1:0] LAST = W'(SEQ_LEN - 1);

  logic [W-1:0] phase_nxt;

  always_comb begin
    phase_nxt = phase;
    if (load_zero) begin
      phase_nxt = '0;
    end else if (en) begin
      phase_nxt = wrap ? '0 : phase + 1'b1;
    end
  end

  // wrap mirrors (phase == LAST) but comes straight from a flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else begin
      phase <= phase_nxt;
      wrap  <= (phase_nxt == LAST);
    end
  end

endmodule

// File: rtl/mseq_sync_ctrl.sv
// rtl/mseq_sync_ctrl.sv - frame acquisition / lock tracking behind the m-sequence correlator
module mseq_sync_ctrl #(
  parameter int SEQ_LEN    = 31,
  parameter int CORR_W     = 8,
  parameter int PEAK_THR   = 56,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int SEARCH_TO  = 124
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_en,
  input  logic [CORR_W-1:0]          corr_data,
  output logic                       locked,
  output logic                       frame_strobe,
  output logic [$clog2(SEQ_LEN)-1:0] phase,
  output logic                       corr_clr,
  output logic [1:0]                 state
);

  import mseq_pkg::*;

  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
  localparam int TMR_W  = $clog2(SEARCH_TO);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SEARCH_TO - 1);

  sync_state_e       st, st_nx;
  logic [HIT_W-1:0]  hit_cnt, hit_nx, hit_inc;
  logic [MISS_W-1:0] miss_cnt, miss_nx, miss_inc;
  logic [TMR_W-1:0]  search_tmr, tmr_nx;
  logic              strobe_nx, clr_nx, ph_load, ph_en;
  logic              peak, window;

  assign peak     = (corr_data >= CORR_W'(PEAK_THR));
  assign hit_inc  = hit_cnt + 1'b1;
  assign miss_inc = miss_cnt + 1'b1;
  assign state    = st;

  mseq_phase_cnt #(.SEQ_LEN(SEQ_LEN)) u_phase (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_zero (ph_load),
    .en        (ph_en),
    .phase     (phase),
    .wrap      (window)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st           <= ST_SEARCH;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      search_tmr   <= '0;
      locked       <= 1'b0;
      frame_strobe <= 1'b0;
      corr_clr     <= 1'b0;
    end else begin
      st           <= st_nx;
      hit_cnt      <= hit_nx;
      miss_cnt     <= miss_nx;
      search_tmr   <= tmr_nx;
      locked       <= (st_nx == ST_LOCKED);
      frame_strobe <= strobe_nx;
      corr_clr     <= clr_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    hit_nx  = hit_cnt;
    miss_nx = miss_cnt;
    tmr_nx  = search_tmr;
    if (sample_en) begin
      case (st)
        ST_SEARCH: begin
          if (peak) begin
            st_nx   = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
            hit_nx  = HIT_W'(1);
            miss_nx = '0;
            tmr_nx  = '0;
          end else begin
            tmr_nx = (search_tmr == TMR_LAST) ? '0 : search_tmr + 1'b1;
          end
        end
        ST_VERIFY: begin
          if (window) begin
            if (peak) begin
              hit_nx = hit_inc;
              if (hit_inc == HIT_W'(LOCK_CNT)) begin
                st_nx   = ST_LOCKED;
                miss_nx = '0;
              end
            end else begin
              st_nx  = ST_SEARCH;
              hit_nx = '0;
              tmr_nx = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (window) begin
            if (peak) begin
              miss_nx = '0;
            end else if (miss_inc == MISS_W'(UNLOCK_CNT)) begin
              st_nx   = ST_SEARCH;
              hit_nx  = '0;
              miss_nx = '0;
              tmr_nx  = '0;
            end else begin
              miss_nx = miss_inc;
            end
          end
        end
        default: st_nx = ST_SEARCH;
      endcase
    end
  end

  // phase only runs once a reference peak has been seen
  always_comb begin
    strobe_nx = 1'b0;
    clr_nx    = 1'b0;
    ph_load   = 1'b0;
    ph_en     = 1'b0;
    if (sample_en) begin
      case (st)
        ST_SEARCH: begin
          if (peak) begin
            ph_load   = 1'b1;
            strobe_nx = (LOCK_CNT == 1);
          end else begin
            clr_nx = (search_tmr == TMR_LAST);
          end
        end
        ST_VERIFY: begin
          ph_en = 1'b1;
          if (window) begin
            if (peak) strobe_nx = (hit_inc == HIT_W'(LOCK_CNT));
            else      clr_nx    = 1'b1;
          end
        end
        ST_LOCKED: begin
          ph_en = 1'b1;
          if (window) begin
            if (peak) strobe_nx = 1'b1;
            else      clr_nx    = (miss_inc == MISS_W'(UNLOCK_CNT));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mseq_sync_ctrl.sv
// tb/tb_mseq_sync_ctrl.sv - scoreboard bench for mseq_sync_ctrl
module tb_mseq_sync_ctrl;
  import mseq_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sample_en = 1'b0;
  logic [CORR_W-1:0]  corr_data = '0;
  logic               locked, frame_strobe, corr_clr;
  logic [PHASE_W-1:0] phase;
  logic [1:0]         state;

  always #5 clk = ~clk;

  mseq_sync_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .corr_data    (corr_data),
    .locked       (locked),
    .frame_strobe (frame_strobe),
    .phase        (phase),
    .corr_clr     (corr_clr),
    .state        (state)
  );

  typedef struct packed {
    logic [1:0]         st;
    logic               lk;
    logic               fs;
    logic               cc;
    logic [PHASE_W-1:0] ph;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference: mode 0/1/2, age = samples since the trigger peak
  int m_mode = 0, m_age = 0, m_hits = 0, m_miss = 0, m_idle = 0, m_phase = 0;
  bit m_fs, m_cc;

  task automatic model_step(input bit rst, input bit en, input int d);
    bit p;
    exp_t e;
    m_fs = 1'b0;
    m_cc = 1'b0;
    p = (d >= PEAK_THR);
    if (rst) begin
      m_mode = 0; m_age = 0; m_hits = 0; m_miss = 0; m_idle = 0; m_phase = 0;
    end else if (en) begin
      if (m_mode == 0) begin
        if (p) begin
          m_age = 0; m_phase = 0; m_hits = 1; m_miss = 0; m_idle = 0;
          if (m_hits == LOCK_CNT) begin m_mode = 2; m_fs = 1'b1; end
          else m_mode = 1;
        end else begin
          m_idle++;
          if (m_idle == SEARCH_TO) begin m_cc = 1'b1; m_idle = 0; end
        end
      end else begin
        m_age++;
        m_phase = m_age % SEQ_LEN;
        if (m_age % SEQ_LEN == 0) begin
          if (m_mode == 1) begin
            if (p) begin
              m_hits++;
              if (m_hits == LOCK_CNT) begin m_mode = 2; m_fs = 1'b1; m_miss = 0; end
            end else begin
              m_mode = 0; m_cc = 1'b1; m_hits = 0; m_idle = 0;
            end
          end else begin
            if (p) begin
              m_fs = 1'b1; m_miss = 0;
            end else begin
              m_miss++;
              if (m_miss == UNLOCK_CNT) begin
                m_mode = 0; m_cc = 1'b1; m_hits = 0; m_miss = 0; m_idle = 0;
              end
            end
          end
        end
      end
    end
    e.st = 2'(m_mode);
    e.lk = (m_mode == 2);
    e.fs = m_fs;
    e.cc = m_cc;
    e.ph = PHASE_W'(m_phase);
    q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit en, input int d);
    @(negedge clk);
    rst_n     = !rst;
    sample_en = en;
    corr_data = CORR_W'(d);
    model_step(rst, en, d);
  endtask

  // n enabled samples; index 0 carries 'first', later multiples of SEQ_LEN carry 'win'
  task automatic samples(input int n, input int first, input int win, input int lo_max, input int gap_pct);
    int d;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) drive(1'b0, 1'b0, $urandom_range(0, 255));
      if (i == 0)                 d = first;
      else if (i % SEQ_LEN == 0)  d = win;
      else                        d = $urandom_range(0, lo_max);
      drive(1'b0, 1'b1, d);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state",        int'(state),        int'(e.st));
        chk("locked",       int'(locked),       int'(e.lk));
        chk("frame_strobe", int'(frame_strobe), int'(e.fs));
        chk("corr_clr",     int'(corr_clr),     int'(e.cc));
        chk("phase",        int'(phase),        int'(e.ph));
      end
    end
  end

  initial begin : stim
    int d;
    repeat (3) drive(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 255));
    samples(SEQ_LEN * 6, PEAK_MAX, PEAK_MAX, PEAK_THR - 1, 20);
    samples(SEQ_LEN * 2, 10, 10, PEAK_THR - 1, 10);
    samples(SEQ_LEN + 1, PEAK_MAX, PEAK_THR - 1, PEAK_THR - 1, 10);
    samples(2 * SEQ_LEN + 1, PEAK_MAX, PEAK_THR, PEAK_THR - 1, 10);
    samples(5, 10, 10, PEAK_THR - 1, 0);
    repeat (3) drive(1'b1, 1'b1, PEAK_MAX);
    samples(2 * SEARCH_TO + 2, 0, 0, 0, 10);
    drive(1'b1, 1'b0, 0);
    samples(SEARCH_TO - 1, 0, 0, 0, 5);
    drive(1'b0, 1'b1, PEAK_MAX);
    samples(SEQ_LEN * 3, 0, PEAK_MAX, PEAK_THR - 1, 0);
    for (int i = 0; i < 3000; i++) begin
      d = ($urandom_range(0, 99) < 8) ? $urandom_range(PEAK_THR, 255) : $urandom_range(0, PEAK_THR - 1);
      drive($urandom_range(0, 999) == 0, $urandom_range(0, 99) < 85, d);
    end
    samples(SEQ_LEN * 5, PEAK_MAX, PEAK_MAX, PEAK_THR - 1, 30);
    @(negedge clk);
    sample_en = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
